// File: rtl/propose_engine_pkg.sv
// rtl/propose_engine_pkg.sv - mode/state encodings and LFSR constants for propose_engine
package propose_engine_pkg;

  typedef enum logic [1:0] {
    PROPOSE_MODE_BOOL = 2'b00,
    PROPOSE_MODE_DISC = 2'b01,
    PROPOSE_MODE_SEG  = 2'b10,
    PROPOSE_MODE_RSVD = 2'b11
  } propose_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_RAND    = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DONE    = 3'd4
  } propose_state_e;

  // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAP_MASK     = 16'hB400;

endpackage

// File: rtl/propose_lfsr.sv
// rtl/propose_lfsr.sv - seedable Galois LFSR with zero-seed guard for propose_engine
module propose_lfsr
  import propose_engine_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAP_MASK),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_DEFAULT_SEED)
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic             in_load,
  input  logic [WIDTH-1:0] in_seed,
  input  logic             in_advance,
  output logic [WIDTH-1:0] out_value
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;

  assign w_next    = {1'b0, r_state[WIDTH-1:1]} ^ (r_state[0] ? TAPS : '0);
  assign out_value = r_state;

  // An all-zero state would lock the register, so a zero seed falls back to SEED
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      r_state <= SEED;
    end else if (in_load) begin
      r_state <= (in_seed == '0) ? SEED : in_seed;
    end else if (in_advance) begin
      r_state <= w_next;
    end
  end

endmodule

// File: rtl/propose_engine.sv
// rtl/propose_engine.sv - MCMC single-variable proposer (bool flip / discrete step / segment draw)
// Optional PROPOSE_CLAMP_EN: saturate mode-01 results and clamp them to the segment bounds.
module propose_engine
  import propose_engine_pkg::*;
#(
  parameter int NUM_VARS   = 8,
  parameter int VAR_WIDTH  = 8,
  parameter int IDX_WIDTH  = 3,
  parameter int STEP_BITS  = 2,
  parameter int LFSR_WIDTH = 16
) (
  input  logic                          in_clock,
  input  logic                          in_reset,
  input  logic                          in_start,
  input  logic [1:0]                    in_mode,
  input  logic [IDX_WIDTH-1:0]          in_index,
  input  logic [NUM_VARS*VAR_WIDTH-1:0] in_current_assignment,
  input  logic [VAR_WIDTH-1:0]          in_seg_start,
  input  logic [VAR_WIDTH-1:0]          in_seg_end,
  input  logic [LFSR_WIDTH-1:0]         in_seed,
  input  logic                          in_seed_load,
  output logic                          out_busy,
  output logic                          out_done,
  output logic [IDX_WIDTH-1:0]          out_index,
  output logic [VAR_WIDTH-1:0]          out_variable_assignment,
  output logic                          out_error
);

  propose_state_e               r_state;
  propose_state_e               w_state_next;
  propose_mode_e                r_mode;
  logic [IDX_WIDTH-1:0]         r_index;
  logic signed [VAR_WIDTH-1:0]  r_cur;
  logic signed [VAR_WIDTH-1:0]  r_seg_start;
  logic signed [VAR_WIDTH-1:0]  r_seg_end;
  logic                         r_idx_bad;
  logic                         r_err;
  logic [VAR_WIDTH:0]           r_span;
  logic [IDX_WIDTH-1:0]         r_out_index;
  logic [VAR_WIDTH-1:0]         r_out_value;
  logic                         r_out_error;

  logic [LFSR_WIDTH-1:0]        w_lfsr;
  logic [VAR_WIDTH-1:0]         w_sel_var;
  logic                         w_index_ok;
  logic                         w_seg_ok;
  logic                         w_err;
  logic [VAR_WIDTH:0]           w_span;
  logic signed [VAR_WIDTH:0]    w_cur_ext;
  logic signed [VAR_WIDTH:0]    w_mag;
  logic signed [VAR_WIDTH:0]    w_disc_ext;
  logic signed [VAR_WIDTH-1:0]  w_disc;
  logic [2*VAR_WIDTH+1:0]       w_prod;
  logic [VAR_WIDTH-1:0]         w_seg_val;
  logic [VAR_WIDTH-1:0]         w_result;
  logic                         w_unused;

  propose_lfsr #(
    .WIDTH (LFSR_WIDTH),
    .TAPS  (LFSR_WIDTH'(LFSR_TAP_MASK)),
    .SEED  (LFSR_WIDTH'(LFSR_DEFAULT_SEED))
  ) u_lfsr (
    .in_clock   (in_clock),
    .in_reset   (in_reset),
    .in_load    ((r_state == ST_IDLE) && in_seed_load),
    .in_seed    (in_seed),
    .in_advance (r_state == ST_RAND),
    .out_value  (w_lfsr)
  );

  // Out-of-range indices select 0 so the error result falls out of the normal path
  always_comb begin
    w_sel_var  = '0;
    w_index_ok = 1'b0;
    for (int i = 0; i < NUM_VARS; i++) begin
      if (in_index == IDX_WIDTH'(i)) begin
        w_sel_var  = in_current_assignment[i*VAR_WIDTH +: VAR_WIDTH];
        w_index_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (in_start) w_state_next = ST_LATCH;
      ST_LATCH:   w_state_next = ST_RAND;
      ST_RAND:    w_state_next = ST_COMPUTE;
      ST_COMPUTE: w_state_next = ST_DONE;
      ST_DONE:    w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    out_busy = 1'b0;
    out_done = 1'b0;
    if (r_state != ST_IDLE) out_busy = 1'b1;
    if (r_state == ST_DONE) out_done = 1'b1;
  end

  assign w_seg_ok  = !(r_seg_start > r_seg_end);
  assign w_err     = r_idx_bad || (r_mode == PROPOSE_MODE_RSVD) ||
                     ((r_mode == PROPOSE_MODE_SEG) && !w_seg_ok);
  assign w_span    = {r_seg_end[VAR_WIDTH-1], r_seg_end} -
                     {r_seg_start[VAR_WIDTH-1], r_seg_start} + (VAR_WIDTH+1)'(1);

  assign w_cur_ext  = {r_cur[VAR_WIDTH-1], r_cur};
  assign w_mag      = (VAR_WIDTH+1)'(w_lfsr[STEP_BITS-1:0]) + (VAR_WIDTH+1)'(1);
  assign w_disc_ext = w_lfsr[LFSR_WIDTH-1] ? (w_cur_ext - w_mag) : (w_cur_ext + w_mag);

`ifdef PROPOSE_CLAMP_EN
  localparam logic signed [VAR_WIDTH:0] DISC_MAX = {2'b00, {(VAR_WIDTH-1){1'b1}}};
  localparam logic signed [VAR_WIDTH:0] DISC_MIN = {2'b11, {(VAR_WIDTH-1){1'b0}}};
  logic signed [VAR_WIDTH:0] w_sat;

  always_comb begin
    w_sat = w_disc_ext;
    if (w_disc_ext > DISC_MAX) begin
      w_sat = DISC_MAX;
    end else if (w_disc_ext < DISC_MIN) begin
      w_sat = DISC_MIN;
    end
    w_disc = w_sat[VAR_WIDTH-1:0];
    if (w_seg_ok) begin
      if (w_disc < r_seg_start) begin
        w_disc = r_seg_start;
      end else if (w_disc > r_seg_end) begin
        w_disc = r_seg_end;
      end
    end
  end
`else
  assign w_disc = w_disc_ext[VAR_WIDTH-1:0];
`endif

  // Scaling a (VAR_WIDTH+1)-bit draw by span keeps the offset strictly below span
  assign w_prod    = (2*VAR_WIDTH+2)'(w_lfsr[VAR_WIDTH:0]) * (2*VAR_WIDTH+2)'(r_span);
  assign w_seg_val = r_seg_start + VAR_WIDTH'(w_prod >> (VAR_WIDTH+1));

  always_comb begin
    w_result = r_cur;
    if (!r_err) begin
      case (r_mode)
        PROPOSE_MODE_BOOL: w_result = r_cur ^ VAR_WIDTH'(1);
        PROPOSE_MODE_DISC: w_result = w_disc;
        PROPOSE_MODE_SEG:  w_result = w_seg_val;
        default:           w_result = r_cur;
      endcase
    end
  end

  assign w_unused = ^{w_lfsr, w_disc_ext};

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      r_mode      <= PROPOSE_MODE_BOOL;
      r_index     <= '0;
      r_cur       <= '0;
      r_seg_start <= '0;
      r_seg_end   <= '0;
      r_idx_bad   <= 1'b0;
      r_err       <= 1'b0;
      r_span      <= '0;
      r_out_index <= '0;
      r_out_value <= '0;
      r_out_error <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && in_start) begin
        r_mode      <= propose_mode_e'(in_mode);
        r_index     <= in_index;
        r_cur       <= w_sel_var;
        r_idx_bad   <= !w_index_ok;
        r_seg_start <= in_seg_start;
        r_seg_end   <= in_seg_end;
      end
      if (r_state == ST_LATCH) begin
        r_err  <= w_err;
        r_span <= w_span;
      end
      if (r_state == ST_COMPUTE) begin
        r_out_index <= r_index;
        r_out_value <= w_result;
        r_out_error <= r_err;
      end
    end
  end

  assign out_index               = r_out_index;
  assign out_variable_assignment = r_out_value;
  assign out_error               = r_out_error;

endmodule
